pipe_hazard_ctrl: RTL

- Pipeline control unit that drives the enable and bubble/flush inputs of the IF_ID, ID_EX and EX_MEM pipeline registers and the PC register.
- Detects load-use hazards, holds the front end while a multi-cycle multiply occupies EX, and flushes wrong-path instructions when a branch or jump resolves taken in MEM.
- Sits beside the datapath. It consumes decoded register indices and control bits from ID, ID_EX and EX_MEM, and produces the en/bubble signals those registers consume.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_if.sv | 37 +++
 rtl/pipe_hazard_ctrl_perf_cnt.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and the datapath.
// No logic here apart from the load-use match helper.
// No backpressure: this package holds definitions only.
package pipe_ctrl_pkg;

    localparam int                   REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] X0_IDX    = '0;
    localparam logic [31:0]          NOP_INST  = 32'h0000_0013;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } hz_state_t;

    // A load whose destination is read by the instruction in ID; x0 never creates a dependency.
    function automatic logic load_use_match(
        input logic                 memread,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 uses_rs2
    );
        return memread && (rd != X0_IDX) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the datapath (master) and the controller (slave).
// Purely wiring; the controller answers combinationally in the same cycle.
// No backpressure: enables/bubbles are the flow control for the pipeline registers.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_IDX_W-1:0] id_rs1;
    logic [REG_IDX_W-1:0] id_rs2;
    logic                 id_uses_rs2;
    logic                 id_ex_memread;
    logic [REG_IDX_W-1:0] id_ex_rd;
    logic                 id_ex_is_mul;
    logic                 mem_branch_taken;

    logic                 en_pc;
    logic                 en_if_id;
    logic                 en_id_ex;
    logic                 flush_if_id;
    logic                 bub_id_ex;
    logic                 bub_ex_mem;
    logic                 stall;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, id_ex_memread, id_ex_rd,
               id_ex_is_mul, mem_branch_taken,
        input  en_pc, en_if_id, en_id_ex, flush_if_id, bub_id_ex,
               bub_ex_mem, stall
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, id_ex_memread, id_ex_rd,
               id_ex_is_mul, mem_branch_taken,
        output en_pc, en_if_id, en_id_ex, flush_if_id, bub_id_ex,
               bub_ex_mem, stall
    );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_cnt.sv
// Free-running 32-bit event counter, wraps at 2^32.
// Latency: count reflects events up to the previous clock edge.
// No backpressure: counts every cycle inc is high.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= 32'd0;
        end else if (inc) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle multiply hold, taken-branch flush.
// Latency: outputs combinational from state+inputs; state/count advance on posedge clk.
// Backpressure: drives register enables/bubbles; HAZARD_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               arst_n,
    pipe_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cycles,
    output logic [31:0]        perf_flush_events
`endif
);

    localparam bit               MUL_EN       = (MUL_LAT > 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

    hz_state_t        state;
    logic [CNT_W-1:0] cnt;

    logic load_use;
    logic mul_start;
    logic branch;

    logic en_pc;
    logic en_if_id;
    logic en_id_ex;
    logic flush_if_id;
    logic bub_id_ex;
    logic bub_ex_mem;
    logic stall;

    assign branch    = hz.mem_branch_taken;
    assign mul_start = MUL_EN && hz.id_ex_is_mul;
    assign load_use  = load_use_match(hz.id_ex_memread, hz.id_ex_rd,
                                      hz.id_rs1, hz.id_rs2, hz.id_uses_rs2);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (branch) begin
            // a multiply caught by a redirect is wrong-path work; drop it
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        state <= MUL_BUSY;
                        cnt   <= MUL_CNT_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        en_pc       = 1'b1;
        en_if_id    = 1'b1;
        en_id_ex    = 1'b1;
        flush_if_id = 1'b0;
        bub_id_ex   = 1'b0;
        bub_ex_mem  = 1'b0;
        stall       = 1'b0;
        if (!arst_n) begin
            // pipeline free-runs while held in reset, whatever the inputs say
        end else if (branch) begin
            flush_if_id = 1'b1;
            bub_id_ex   = 1'b1;
            bub_ex_mem  = 1'b1;
        end else if ((state == MUL_BUSY && cnt != '0) || (state == IDLE && mul_start)) begin
            en_pc      = 1'b0;
            en_if_id   = 1'b0;
            en_id_ex   = 1'b0;
            bub_ex_mem = 1'b1;
            stall      = 1'b1;
        end else if (state == IDLE && load_use) begin
            en_pc     = 1'b0;
            en_if_id  = 1'b0;
            bub_id_ex = 1'b1;
            stall     = 1'b1;
        end
    end

    assign hz.en_pc       = en_pc;
    assign hz.en_if_id    = en_if_id;
    assign hz.en_id_ex    = en_id_ex;
    assign hz.flush_if_id = flush_if_id;
    assign hz.bub_id_ex   = bub_id_ex;
    assign hz.bub_ex_mem  = bub_ex_mem;
    assign hz.stall       = stall;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (stall),
        .count  (perf_stall_cycles)
    );

    hazard_perf_cnt u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (branch),
        .count  (perf_flush_events)
    );
`endif

endmodule
